// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: access-size encodings, FSM states
// and the sizing helper for the bus-timeout counter.
package mem_pkg;

    // RV32I load/store size and sign encodings (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Bits needed to count 0 .. max_wait-1 (at least one bit)
    function automatic int cnt_width(input int max_wait);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < max_wait) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Selects the addressed byte/halfword of a read word and sign- or
// zero-extends it according to the load funct3.
module load_formatter
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    output logic [31:0] data_out
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Lane extraction and extension; unsupported encodings read as zero
    always_comb begin
        lane_byte = 8'h00;
        lane_half = byte_off[1] ? rdata[31:16] : rdata[15:0];
        data_out  = 32'h0;
        case (byte_off)
            2'd0: lane_byte = rdata[7:0];
            2'd1: lane_byte = rdata[15:8];
            2'd2: lane_byte = rdata[23:16];
            default: lane_byte = rdata[31:24];
        endcase
        case (funct3)
            F3_B:    data_out = {{24{lane_byte[7]}}, lane_byte};
            F3_BU:   data_out = {24'h0, lane_byte};
            F3_H:    data_out = {{16{lane_half[15]}}, lane_half};
            F3_HU:   data_out = {16'h0, lane_half};
            F3_W:    data_out = rdata;
            default: data_out = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory requests over a req/ack bus,
// formats store lanes and load results, stalls upstream while a transfer
// is outstanding, and flags illegal accesses and bus timeouts.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 16
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic [2:0]        funct3_in,
    input  logic [ADDR_W-1:0] alu_result_in,
    input  logic [31:0]       store_data_in,
    input  logic [4:0]        rd_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              stall,
    output logic              RegWrite_out,
    output logic              MemtoReg_out,
    output logic [31:0]       alu_result_out,
    output logic [31:0]       mem_read_data_out,
    output logic [4:0]        rd_out,
    output logic              misalign_fault,
    output logic              bus_fault
);

    localparam int              CNT_W    = cnt_width(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_n;

    // Request fields captured when a transfer has to wait for ack
    logic [ADDR_W-1:0] addr_p1;
    logic              we_p1;
    logic [3:0]        be_p1;
    logic [31:0]       wdata_p1;
    logic [2:0]        funct3_p1;
    logic [1:0]        off_p1;

    logic              misalign_q, bus_fault_q;

    // Decode of the instruction currently in the EX/MEM slot
    logic              is_mem, illegal;
    logic [ADDR_W-1:0] new_addr;
    logic [3:0]        new_be;
    logic [31:0]       new_wdata;

    // Combinational request/response values before reset masking
    logic              req_c, we_c, stall_c, regwrite_c;
    logic [ADDR_W-1:0] addr_c;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c, rdata_c;
    logic              latch_c, illegal_c, timeout_c;

    logic [2:0]        fmt_f3;
    logic [1:0]        fmt_off;
    logic [31:0]       fmt_data;

    // A waiting load is formatted with the size/offset captured at issue
    assign fmt_f3  = (state == WAIT) ? funct3_p1 : funct3_in;
    assign fmt_off = (state == WAIT) ? off_p1    : alu_result_in[1:0];

    load_formatter u_fmt (
        .rdata   (dmem_rdata),
        .funct3  (fmt_f3),
        .byte_off(fmt_off),
        .data_out(fmt_data)
    );

    // Address alignment, store lane formatting and legality checks
    always_comb begin
        is_mem    = MemRead_in | MemWrite_in;
        new_addr  = {alu_result_in[ADDR_W-1:2], 2'b00};
        new_be    = 4'b1111;
        new_wdata = 32'h0;
        illegal   = 1'b0;
        if (MemWrite_in) begin
            case (funct3_in)
                F3_B: begin
                    new_be    = 4'b0001 << alu_result_in[1:0];
                    new_wdata = {4{store_data_in[7:0]}};
                end
                F3_H: begin
                    new_be    = alu_result_in[1] ? 4'b1100 : 4'b0011;
                    new_wdata = {2{store_data_in[15:0]}};
                end
                default: begin
                    new_be    = 4'b1111;
                    new_wdata = store_data_in;
                end
            endcase
        end
        if (MemRead_in && MemWrite_in) begin
            illegal = 1'b1;
        end
        if (MemRead_in && (funct3_in == 3'b011 || funct3_in == 3'b110 ||
                           funct3_in == 3'b111)) begin
            illegal = 1'b1;
        end
        if (MemWrite_in && !(funct3_in == F3_B || funct3_in == F3_H ||
                             funct3_in == F3_W)) begin
            illegal = 1'b1;
        end
        if (funct3_in[1:0] == 2'b01 && alu_result_in[0]) begin
            illegal = 1'b1;
        end
        if (funct3_in[1:0] == 2'b10 && alu_result_in[1:0] != 2'b00) begin
            illegal = 1'b1;
        end
    end

    // Next-state logic and bus/response outputs
    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        req_c      = 1'b0;
        we_c       = 1'b0;
        addr_c     = '0;
        be_c       = 4'b0000;
        wdata_c    = 32'h0;
        stall_c    = 1'b0;
        regwrite_c = 1'b0;
        rdata_c    = 32'h0;
        latch_c    = 1'b0;
        illegal_c  = 1'b0;
        timeout_c  = 1'b0;
        case (state)
            IDLE: begin
                wait_cnt_n = '0;
                if (in_valid && !is_mem) begin
                    regwrite_c = RegWrite_in;
                end else if (in_valid && illegal) begin
                    illegal_c = 1'b1;
                end else if (in_valid) begin
                    req_c   = 1'b1;
                    we_c    = MemWrite_in;
                    addr_c  = new_addr;
                    be_c    = new_be;
                    wdata_c = new_wdata;
                    if (dmem_ack) begin
                        regwrite_c = RegWrite_in;
                        rdata_c    = MemRead_in ? fmt_data : 32'h0;
                    end else begin
                        latch_c = 1'b1;
                        stall_c = 1'b1;
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == CNT_LAST) begin
                    // Timeout: release the bus and let the squashed op leave
                    timeout_c  = 1'b1;
                    state_n    = IDLE;
                    wait_cnt_n = '0;
                end else begin
                    req_c   = 1'b1;
                    we_c    = we_p1;
                    addr_c  = addr_p1;
                    be_c    = be_p1;
                    wdata_c = wdata_p1;
                    if (dmem_ack) begin
                        regwrite_c = RegWrite_in;
                        rdata_c    = we_p1 ? 32'h0 : fmt_data;
                        state_n    = IDLE;
                        wait_cnt_n = '0;
                    end else begin
                        stall_c    = 1'b1;
                        wait_cnt_n = wait_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n    = IDLE;
                wait_cnt_n = '0;
            end
        endcase
    end

    // FSM state, wait counter and fault pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            misalign_q  <= 1'b0;
            bus_fault_q <= 1'b0;
        end else begin
            state       <= state_n;
            wait_cnt    <= wait_cnt_n;
            misalign_q  <= illegal_c;
            bus_fault_q <= timeout_c;
        end
    end

    // Capture the request when the first attempt is not acknowledged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_p1   <= '0;
            we_p1     <= 1'b0;
            be_p1     <= 4'b0000;
            wdata_p1  <= 32'h0;
            funct3_p1 <= 3'b000;
            off_p1    <= 2'b00;
        end else if (latch_c) begin
            addr_p1   <= new_addr;
            we_p1     <= MemWrite_in;
            be_p1     <= new_be;
            wdata_p1  <= new_wdata;
            funct3_p1 <= funct3_in;
            off_p1    <= alu_result_in[1:0];
        end
    end

    // All outputs are forced low while reset is asserted
    always_comb begin
        dmem_req          = 1'b0;
        dmem_we           = 1'b0;
        dmem_addr         = '0;
        dmem_be           = 4'b0000;
        dmem_wdata        = 32'h0;
        stall             = 1'b0;
        RegWrite_out      = 1'b0;
        MemtoReg_out      = 1'b0;
        alu_result_out    = 32'h0;
        mem_read_data_out = 32'h0;
        rd_out            = 5'd0;
        misalign_fault    = 1'b0;
        bus_fault         = 1'b0;
        if (!reset) begin
            dmem_req          = req_c;
            dmem_we           = we_c;
            dmem_addr         = addr_c;
            dmem_be           = be_c;
            dmem_wdata        = wdata_c;
            stall             = stall_c;
            RegWrite_out      = regwrite_c;
            MemtoReg_out      = MemtoReg_in;
            alu_result_out    = 32'(alu_result_in);
            mem_read_data_out = rdata_c;
            rd_out            = rd_in;
            misalign_fault    = misalign_q;
            bus_fault         = bus_fault_q;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with hand-computed expectations.
module tb_mem_access_stage;

    logic        clk;
    logic        reset;
    logic        in_valid, RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in;
    logic [2:0]  funct3_in;
    logic [31:0] alu_result_in, store_data_in;
    logic [4:0]  rd_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall, RegWrite_out, MemtoReg_out;
    logic [31:0] alu_result_out, mem_read_data_out;
    logic [4:0]  rd_out;
    logic        misalign_fault, bus_fault;

    int n_cmp = 0;
    int n_mis = 0;

    mem_access_stage #(.ADDR_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .funct3_in(funct3_in), .alu_result_in(alu_result_in),
        .store_data_in(store_data_in), .rd_in(rd_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .stall(stall),
        .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
        .alu_result_out(alu_result_out), .mem_read_data_out(mem_read_data_out),
        .rd_out(rd_out), .misalign_fault(misalign_fault), .bus_fault(bus_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r,
                         input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] rd);
        in_valid = v; RegWrite_in = rw; MemtoReg_in = m2r;
        MemRead_in = mr; MemWrite_in = mw; funct3_in = f3;
        alu_result_in = a; store_data_in = sd; rd_in = rd;
    endtask

    task automatic bus(input logic ack, input logic [31:0] rdat);
        dmem_ack = ack; dmem_rdata = rdat;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1, 1, 1, 1, 0, 3'b010, 32'h100, 32'h0, 5'd3);
        bus(1, 32'hDEADBEEF);
        #2;
        // Outputs held low during reset even with a live op on the inputs
        chk("rst_req", 32'(dmem_req), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_regwr", 32'(RegWrite_out), 32'h0);
        chk("rst_alu", alu_result_out, 32'h0);
        chk("rst_rdata", mem_read_data_out, 32'h0);
        tick(); tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        bus(0, 32'h0);
        #2;
        chk("idle_misalign", 32'(misalign_fault), 32'h0);
        chk("idle_busfault", 32'(bus_fault), 32'h0);

        // Non-memory pass-through
        tick();
        drive(1, 1, 0, 0, 0, 3'b000, 32'h12345678, 32'h0, 5'd7);
        #2;
        chk("alu_req", 32'(dmem_req), 32'h0);
        chk("alu_regwr", 32'(RegWrite_out), 32'h1);
        chk("alu_result", alu_result_out, 32'h12345678);
        chk("alu_rd", 32'(rd_out), 32'd7);
        chk("alu_rdata", mem_read_data_out, 32'h0);

        // Bubble: RegWrite_out suppressed, fields pass through
        tick();
        drive(0, 1, 1, 0, 0, 3'b000, 32'h55, 32'h0, 5'd9);
        #2;
        chk("bubble_regwr", 32'(RegWrite_out), 32'h0);
        chk("bubble_rd", 32'(rd_out), 32'd9);

        // Zero-wait LW
        tick();
        drive(1, 1, 1, 1, 0, 3'b010, 32'h100, 32'h0, 5'd5);
        bus(1, 32'hDEADBEEF);
        #2;
        chk("lw0_req", 32'(dmem_req), 32'h1);
        chk("lw0_we", 32'(dmem_we), 32'h0);
        chk("lw0_addr", dmem_addr, 32'h100);
        chk("lw0_be", 32'(dmem_be), 32'hF);
        chk("lw0_stall", 32'(stall), 32'h0);
        chk("lw0_data", mem_read_data_out, 32'hDEADBEEF);
        chk("lw0_regwr", 32'(RegWrite_out), 32'h1);
        chk("lw0_m2r", 32'(MemtoReg_out), 32'h1);

        // LB at 0x103 with three wait states
        tick();
        drive(1, 1, 1, 1, 0, 3'b000, 32'h103, 32'h0, 5'd6);
        bus(0, 32'h80112233);
        #2;
        chk("lb_c0_stall", 32'(stall), 32'h1);
        chk("lb_c0_regwr", 32'(RegWrite_out), 32'h0);
        chk("lb_c0_addr", dmem_addr, 32'h100);
        chk("lb_c0_data", mem_read_data_out, 32'h0);
        tick();
        #2;
        chk("lb_c1_stall", 32'(stall), 32'h1);
        chk("lb_c1_req", 32'(dmem_req), 32'h1);
        chk("lb_c1_be", 32'(dmem_be), 32'hF);
        tick();
        alu_result_in = 32'h200;
        #2;
        chk("lb_c2_stall", 32'(stall), 32'h1);
        chk("lb_c2_addr_held", dmem_addr, 32'h100);
        tick();
        alu_result_in = 32'h103;
        bus(1, 32'h80112233);
        #2;
        chk("lb_c3_stall", 32'(stall), 32'h0);
        chk("lb_c3_data", mem_read_data_out, 32'hFFFFFF80);
        chk("lb_c3_regwr", 32'(RegWrite_out), 32'h1);

        // LBU at 0x103, one wait state
        tick();
        drive(1, 1, 1, 1, 0, 3'b100, 32'h103, 32'h0, 5'd6);
        bus(0, 32'h80112233);
        #2;
        chk("lbu_c0_stall", 32'(stall), 32'h1);
        tick();
        bus(1, 32'h80112233);
        #2;
        chk("lbu_data", mem_read_data_out, 32'h00000080);
        chk("lbu_stall", 32'(stall), 32'h0);

        // LH at 0x102 (sign) and LHU at 0x100 (zero), zero wait
        tick();
        drive(1, 1, 1, 1, 0, 3'b001, 32'h102, 32'h0, 5'd8);
        #2;
        chk("lh_data", mem_read_data_out, 32'hFFFF8011);
        tick();
        drive(1, 1, 1, 1, 0, 3'b101, 32'h100, 32'h0, 5'd8);
        #2;
        chk("lhu_data", mem_read_data_out, 32'h00002233);

        // SH at 0x102
        tick();
        drive(1, 0, 0, 0, 1, 3'b001, 32'h102, 32'h0000ABCD, 5'd0);
        bus(1, 32'h0);
        #2;
        chk("sh_be", 32'(dmem_be), 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
        chk("sh_we", 32'(dmem_we), 32'h1);
        chk("sh_addr", dmem_addr, 32'h100);
        chk("sh_regwr", 32'(RegWrite_out), 32'h0);
        chk("sh_data", mem_read_data_out, 32'h0);

        // SB at 0x101 and SW
        tick();
        drive(1, 0, 0, 0, 1, 3'b000, 32'h101, 32'h1234565A, 5'd0);
        #2;
        chk("sb_be", 32'(dmem_be), 32'h2);
        chk("sb_wdata", dmem_wdata, 32'h5A5A5A5A);
        tick();
        drive(1, 0, 0, 0, 1, 3'b010, 32'h104, 32'hCAFEF00D, 5'd0);
        #2;
        chk("sw_be", 32'(dmem_be), 32'hF);
        chk("sw_wdata", dmem_wdata, 32'hCAFEF00D);

        // Misaligned LW at 0x101
        tick();
        drive(1, 1, 1, 1, 0, 3'b010, 32'h101, 32'h0, 5'd4);
        bus(0, 32'h0);
        #2;
        chk("mis_req", 32'(dmem_req), 32'h0);
        chk("mis_stall", 32'(stall), 32'h0);
        chk("mis_regwr", 32'(RegWrite_out), 32'h0);
        chk("mis_fault_now", 32'(misalign_fault), 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        #2;
        chk("mis_fault_pulse", 32'(misalign_fault), 32'h1);
        tick();
        #2;
        chk("mis_fault_end", 32'(misalign_fault), 32'h0);

        // Read+write together is illegal
        drive(1, 1, 0, 1, 1, 3'b010, 32'h100, 32'h0, 5'd4);
        #2;
        chk("rw_req", 32'(dmem_req), 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        #2;
        chk("rw_fault", 32'(misalign_fault), 32'h1);

        // Bus timeout with MAX_WAIT=4: req high 4 cycles, drop on 5th
        tick();
        drive(1, 1, 1, 1, 0, 3'b010, 32'h100, 32'h0, 5'd2);
        bus(0, 32'h0);
        #2;
        chk("to_c0_req", 32'(dmem_req), 32'h1);
        tick(); #2;
        chk("to_c1_req", 32'(dmem_req), 32'h1);
        tick(); #2;
        chk("to_c2_req", 32'(dmem_req), 32'h1);
        tick(); #2;
        chk("to_c3_req", 32'(dmem_req), 32'h1);
        chk("to_c3_stall", 32'(stall), 32'h1);
        tick(); #2;
        chk("to_c4_req", 32'(dmem_req), 32'h0);
        chk("to_c4_stall", 32'(stall), 32'h0);
        chk("to_c4_regwr", 32'(RegWrite_out), 32'h0);
        chk("to_c4_fault", 32'(bus_fault), 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        bus(1, 32'h11111111);
        #2;
        chk("to_fault_pulse", 32'(bus_fault), 32'h1);
        chk("to_late_ack_req", 32'(dmem_req), 32'h0);
        chk("to_late_ack_data", mem_read_data_out, 32'h0);
        tick();
        bus(0, 32'h0);
        #2;
        chk("to_fault_end", 32'(bus_fault), 32'h0);
        chk("to_idle_stall", 32'(stall), 32'h0);

        // Reset in WAIT cycle 2 drops req at once
        tick();
        drive(1, 1, 1, 1, 0, 3'b010, 32'h100, 32'h0, 5'd2);
        #2;
        tick(); #2;
        tick(); #2;
        chk("rw2_req_before", 32'(dmem_req), 32'h1);
        reset = 1'b1;
        #1;
        chk("rw2_req_async", 32'(dmem_req), 32'h0);
        chk("rw2_stall_async", 32'(stall), 32'h0);
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        #2;
        chk("rw2_no_bus_fault", 32'(bus_fault), 32'h0);
        chk("rw2_no_mis_fault", 32'(misalign_fault), 32'h0);

        // Fresh LW after reset: two waits then ack, no early timeout
        tick();
        drive(1, 1, 1, 1, 0, 3'b010, 32'h104, 32'h0, 5'd1);
        bus(0, 32'h01020304);
        #2;
        chk("post_c0_stall", 32'(stall), 32'h1);
        tick(); #2;
        chk("post_c1_stall", 32'(stall), 32'h1);
        tick();
        bus(1, 32'h01020304);
        #2;
        chk("post_c2_req", 32'(dmem_req), 32'h1);
        chk("post_c2_addr", dmem_addr, 32'h104);
        chk("post_c2_data", mem_read_data_out, 32'h01020304);
        chk("post_c2_regwr", 32'(RegWrite_out), 32'h1);
        tick();
        drive(0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        bus(0, 32'h0);
        #2;
        chk("post_idle_stall", 32'(stall), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
